uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
Parametrised oversampling UART receiver, the next generation of the team's fixed 8N1/8O1 receiver. Adds configurable word length, parity mode, stop bits and oversampling ratio, plus 3-sample majority voting and false-start rejection. Reports parity, framing, overrun and break conditions. Sits between the baud-tick generator and the consumer (FIFO or register bank) and delivers words over a valid/ready handshake.

Parameters:
DATA_BITS, 8, word length; legal values 5..9
PARITY, "ODD", one of "NONE", "EVEN" or "ODD"
STOP_BITS, 1, 1 or 2
OVERSAMPLE, 8, ticks per bit; even, 8..16; sample counter width is $clog2(OVERSAMPLE)

Ports:
clk  in  1  system clock; the only clock in the block
rst  in  1  synchronous, active-high reset
os_tick  in  1  one-clk strobe at OVERSAMPLE x baud rate
rxd  in  1  asynchronous serial input; idles high
rx_data  out  DATA_BITS  received word, LSB first on the line
rx_valid  out  1  rx_data and the error flags are valid
rx_ready  in  1  consumer accepts the word when rx_valid && rx_ready
parity_err  out  1  parity mismatch for the current word; 0 when PARITY="NONE"
frame_err  out  1  a stop bit was sampled low
break_det  out  1  break frame: all data, parity and stop samples were 0
overrun  out  1  one-clk pulse: a completed frame was dropped

Behaviour:
- Reset (synchronous, clk edge with rst=1): all outputs 0, FSM to IDLE, counters 0, synchroniser flops set to 1. rst asserted mid-frame abandons the frame with no output.
- rxd passes through a 2-FF synchroniser clocked every clk. The 3-deep shift register for majority voting advances only on os_tick. All FSM activity is gated by os_tick.
- Majority vote: bit value = majority of the 3 samples taken on the ticks at counts C-1, C and C+1, where C = OVERSAMPLE/2. The decision is made at tick C+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- IDLE: on a tick where the synchronised sample is 0 and the previous sample was 1, clear the counter and go to START.
- START: count ticks. At count C+1, if the vote is 1, treat it as a false start and return to IDLE. Otherwise continue.
- Bit timing: each bit period is OVERSAMPLE ticks measured from the start edge. The counter wraps from OVERSAMPLE-1 to 0.
- DATA: DATA_BITS votes, shifted LSB first.
- PARITY: entered only if PARITY is not "NONE". For "EVEN" the expected bit is ^data; for "ODD" it is ~^data. A mismatch sets the internal perr.
- STOP: STOP_BITS votes. Any 0 sets the internal ferr.
- Frame completion at the final stop-bit decision tick. On the next clk:
  - if rx_valid=0 or the word is accepted in that same cycle: load rx_data, parity_err, frame_err and break_det, and set rx_valid=1;
  - otherwise: keep the old word and flags, pulse overrun for one clk, and drop the new frame.
- Break: data=0, parity sample 0 (if present) and all stop samples 0. Break sets break_det=1 and frame_err=1, and parity_err is forced to 0. The FSM then goes to BREAK_WAIT, which returns to IDLE only after OVERSAMPLE consecutive ticks sampling 1.
- Non-break framing error: return to IDLE immediately. No BREAK_WAIT.
- Handshake: rx_valid stays high until rx_valid && rx_ready. rx_data and the flags are stable while rx_valid=1. After acceptance with no new frame completing, rx_valid=0 on the next clk and the flags clear with it.
- Latency: rx_valid rises 1 clk after the os_tick of the final stop-bit decision.
- The receiver re-arms in IDLE straight from STOP, independent of the consumer. There is no rx_ack gating.
- os_tick=0 freezes the FSM; only the handshake logic runs.

Decomposition:
- Shared definitions file uart_defs: FSM state encodings (3-bit localparams), parity mode constants, and the max/min DATA_BITS and OVERSAMPLE limits. The same file is used by the transmitter.
- One sub-module, uart_rx_sampler: 2-FF synchroniser, tick-gated 3-sample shift register, majority output and falling-edge detect. Parameter: none. Outputs: samp, vote, fall.

Test Plan:
1. OVERSAMPLE=8, DATA_BITS=8, ODD, 1 stop; send 0xA5 with parity bit 1 -> rx_data=0xA5, rx_valid=1, all error flags 0, rx_valid rising 1 clk after the stop-bit decision tick.
2. Same configuration, send 0xA5 with parity bit 0 -> rx_data=0xA5, parity_err=1; next frame 0x3C with correct parity -> parity_err=0.
3. Stop bit driven 0 on 0x5A -> frame_err=1, break_det=0; FSM back in IDLE and the next frame 0x01 is received cleanly. Separately, a 2-tick low glitch on idle rxd -> no rx_valid.
4. rx_ready held 0; send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses exactly 1 clk. Raise rx_ready -> 0x11 accepted, rx_valid=0; 0x22 is never delivered.
5. rxd low for 12 bit periods, then high -> break_det=1, frame_err=1, rx_data=0x00. No second frame until rxd has been high for 8 ticks; the following 0x7E is received correctly.
6. Configuration DATA_BITS=7, EVEN, 2 stops, OVERSAMPLE=16: send 0x41 -> rx_data=0x41. Second stop bit low -> frame_err=1. rst pulsed mid-data on a later frame -> no rx_valid and all outputs 0.

Source files
------------

// File: rtl/uart_rx_os_pkg.sv
// Shared UART definitions: FSM state codes, parity modes, configuration limits
// and the per-word status flag payload.
package uart_rx_os_pkg;

  localparam int unsigned ST_W      = 3;
  localparam int unsigned BIT_CNT_W = 4;

  localparam logic [ST_W-1:0] ST_IDLE       = 3'd0;
  localparam logic [ST_W-1:0] ST_START      = 3'd1;
  localparam logic [ST_W-1:0] ST_DATA       = 3'd2;
  localparam logic [ST_W-1:0] ST_PARITY     = 3'd3;
  localparam logic [ST_W-1:0] ST_STOP       = 3'd4;
  localparam logic [ST_W-1:0] ST_BREAK_WAIT = 3'd5;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  localparam int unsigned DATA_BITS_MIN  = 5;
  localparam int unsigned DATA_BITS_MAX  = 9;
  localparam int unsigned OVERSAMPLE_MIN = 8;
  localparam int unsigned OVERSAMPLE_MAX = 16;

  typedef enum logic [ST_W-1:0] {
    S_IDLE       = ST_IDLE,
    S_START      = ST_START,
    S_DATA       = ST_DATA,
    S_PARITY     = ST_PARITY,
    S_STOP       = ST_STOP,
    S_BREAK_WAIT = ST_BREAK_WAIT
  } rx_state_e;

  typedef struct packed {
    logic perr;
    logic ferr;
    logic brk;
  } rx_flags_t;

endpackage

// File: rtl/uart_rx_sampler.sv
// Input conditioning for the UART receiver: 2-FF synchroniser, tick-gated
// sample history, 3-sample majority vote and falling-edge detect.
module uart_rx_sampler
  import uart_rx_os_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic os_tick,
  input  logic rxd,
  output logic samp,
  output logic vote,
  output logic fall
);

  logic       r_sync1;
  logic       r_sync2;
  logic [1:0] r_hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  // The live sample plus two ticks of history form the 3-sample window, so the
  // vote is available on the tick of the third sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist <= 2'b11;
    end else if (os_tick) begin
      r_hist <= {r_hist[0], r_sync2};
    end
  end

  assign samp = r_sync2;
  assign vote = (r_sync2 & r_hist[0]) | (r_sync2 & r_hist[1]) | (r_hist[0] & r_hist[1]);
  assign fall = r_hist[0] & ~r_sync2;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with configurable framing, majority voting,
// false-start rejection, error/break reporting and a valid/ready output.
module uart_rx_os
  import uart_rx_os_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter string       PARITY     = "ODD",
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 os_tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_DEC = CNT_W'(OVERSAMPLE / 2 + 1);
  localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] STOP_LAST = BIT_CNT_W'(STOP_BITS - 1);
  localparam logic [1:0] PMODE = (PARITY == "NONE") ? PAR_NONE :
                                 (PARITY == "EVEN") ? PAR_EVEN : PAR_ODD;
  localparam bit CFG_OK = (DATA_BITS >= DATA_BITS_MIN) && (DATA_BITS <= DATA_BITS_MAX) &&
                          (OVERSAMPLE >= OVERSAMPLE_MIN) && (OVERSAMPLE <= OVERSAMPLE_MAX) &&
                          (OVERSAMPLE % 2 == 0) && (STOP_BITS >= 1) && (STOP_BITS <= 2) &&
                          ((PARITY == "NONE") || (PARITY == "EVEN") || (PARITY == "ODD"));

  if (!CFG_OK) begin : g_cfg_err
    $error("uart_rx_os: illegal parameter combination");
  end

  logic w_samp;
  logic w_vote;
  logic w_fall;

  uart_rx_sampler u_sampler (
    .clk     (clk),
    .rst     (rst),
    .os_tick (os_tick),
    .rxd     (rxd),
    .samp    (w_samp),
    .vote    (w_vote),
    .fall    (w_fall)
  );

  rx_state_e            r_state, w_state_nx;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nx, w_cnt_inc;
  logic [BIT_CNT_W-1:0] r_bit, w_bit_nx;
  logic [DATA_BITS-1:0] r_shift, w_shift_nx;
  logic                 r_perr, w_perr_nx;
  logic                 r_ferr, w_ferr_nx;
  logic                 r_any1, w_any1_nx;
  logic                 w_dec;
  logic                 w_par_exp;
  logic                 w_done;
  rx_flags_t            w_flags;

  logic [DATA_BITS-1:0] r_rx_data;
  rx_flags_t            r_flags;
  logic                 r_valid;
  logic                 r_overrun;

  assign w_cnt_inc = (r_cnt == CNT_TOP) ? '0 : r_cnt + CNT_W'(1);
  assign w_dec     = (w_cnt_inc == CNT_DEC);
  assign w_par_exp = (PMODE == PAR_EVEN) ? ^r_shift : ~^r_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_any1  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
      r_perr  <= w_perr_nx;
      r_ferr  <= w_ferr_nx;
      r_any1  <= w_any1_nx;
    end
  end

  // Frame FSM: every bit decision lands on count C+1 of its bit period.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_perr_nx  = r_perr;
    w_ferr_nx  = r_ferr;
    w_any1_nx  = r_any1;
    w_done     = 1'b0;
    w_flags    = '0;
    if (os_tick) begin
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            w_state_nx = S_START;
            w_cnt_nx   = '0;
            w_bit_nx   = '0;
            w_perr_nx  = 1'b0;
            w_ferr_nx  = 1'b0;
            w_any1_nx  = 1'b0;
          end
        end
        S_START: begin
          w_cnt_nx = w_cnt_inc;
          if (w_dec) w_state_nx = w_vote ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          w_cnt_nx = w_cnt_inc;
          if (w_dec) begin
            w_shift_nx = {w_vote, r_shift[DATA_BITS-1:1]};
            w_any1_nx  = r_any1 | w_vote;
            if (r_bit == DATA_LAST) begin
              w_bit_nx   = '0;
              w_state_nx = (PMODE == PAR_NONE) ? S_STOP : S_PARITY;
            end else begin
              w_bit_nx = r_bit + BIT_CNT_W'(1);
            end
          end
        end
        S_PARITY: begin
          w_cnt_nx = w_cnt_inc;
          if (w_dec) begin
            w_any1_nx  = r_any1 | w_vote;
            w_perr_nx  = (w_vote != w_par_exp);
            w_state_nx = S_STOP;
          end
        end
        S_STOP: begin
          w_cnt_nx = w_cnt_inc;
          if (w_dec) begin
            w_ferr_nx = r_ferr | ~w_vote;
            w_any1_nx = r_any1 | w_vote;
            if (r_bit == STOP_LAST) begin
              w_done       = 1'b1;
              w_flags.brk  = ~w_any1_nx;
              w_flags.ferr = w_ferr_nx;
              w_flags.perr = r_perr & ~w_flags.brk;
              w_state_nx   = w_flags.brk ? S_BREAK_WAIT : S_IDLE;
              w_cnt_nx     = '0;
            end else begin
              w_bit_nx = r_bit + BIT_CNT_W'(1);
            end
          end
        end
        S_BREAK_WAIT: begin
          if (!w_samp) begin
            w_cnt_nx = '0;
          end else if (r_cnt == CNT_TOP) begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + CNT_W'(1);
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // Output holding register; a frame finishing while the old word is pending is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_data <= '0;
      r_flags   <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_done && (!r_valid || rx_ready)) begin
        r_rx_data <= r_shift;
        r_flags   <= w_flags;
        r_valid   <= 1'b1;
      end else begin
        if (w_done) r_overrun <= 1'b1;
        if (r_valid && rx_ready) begin
          r_valid <= 1'b0;
          r_flags <= '0;
        end
      end
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_valid;
  assign parity_err = r_flags.perr;
  assign frame_err  = r_flags.ferr;
  assign break_det  = r_flags.brk;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: an 8O1/OS8 instance and a 7E2/OS16 instance
// driven with directed frames; monitors compare each accepted word.
module tb_uart_rx_os;

  logic clk;
  logic rst;
  logic os_tick;
  logic rxd_a, rxd_b, ready_a, ready_b;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic valid_a, perr_a, ferr_a, brk_a, ovr_a;
  logic valid_b, perr_b, ferr_b, brk_b, ovr_b;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  int n_checks = 0;
  int n_pass   = 0;
  int ovr_cnt_a = 0;
  int ovr_cnt_b = 0;
  logic pv_a = 1'b0, pv_b = 1'b0, pt_a = 1'b0, pt_b = 1'b0;

  uart_rx_os #(.DATA_BITS(8), .PARITY("ODD"), .STOP_BITS(1), .OVERSAMPLE(8)) u_dut_a (
    .clk(clk), .rst(rst), .os_tick(os_tick), .rxd(rxd_a),
    .rx_data(data_a), .rx_valid(valid_a), .rx_ready(ready_a),
    .parity_err(perr_a), .frame_err(ferr_a), .break_det(brk_a), .overrun(ovr_a)
  );

  uart_rx_os #(.DATA_BITS(7), .PARITY("EVEN"), .STOP_BITS(2), .OVERSAMPLE(16)) u_dut_b (
    .clk(clk), .rst(rst), .os_tick(os_tick), .rxd(rxd_b),
    .rx_data(data_b), .rx_valid(valid_b), .rx_ready(ready_b),
    .parity_err(perr_b), .frame_err(ferr_b), .break_det(brk_b), .overrun(ovr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-clk os_tick every 4 clks.
  initial begin
    os_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 os_tick = 1'b1;
      @(posedge clk);
      #1 os_tick = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input bit to_b, input logic [8:0] d, input logic pe, input logic fe, input logic bk);
    exp_t e;
    e.data = d; e.perr = pe; e.ferr = fe; e.brk = bk;
    if (to_b) q_b.push_back(e);
    else q_a.push_back(e);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!os_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic drive(input bit to_b, input logic v, input int n);
    if (to_b) rxd_b = v;
    else rxd_a = v;
    wait_ticks(n);
  endtask

  task automatic send_frame(input bit to_b, input logic [8:0] d, input int nbits, input logic par,
                            input logic [1:0] stops, input int nstops, input int os);
    drive(to_b, 1'b0, os);
    for (int i = 0; i < nbits; i++) drive(to_b, d[i], os);
    drive(to_b, par, os);
    for (int i = 0; i < nstops; i++) drive(to_b, stops[i], os);
    drive(to_b, 1'b1, 2 * os);
  endtask

  // Monitor A: latency of each rx_valid rise, and word/flag compare on acceptance.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_a && !pv_a) chk("a_valid_after_tick", 32'(pt_a), 32'd1);
      if (valid_a && ready_a) begin
        if (q_a.size() == 0) begin
          n_checks++;
          $display("FAIL a_unexpected_word: got 0x%0h expected no word", data_a);
        end else begin
          e_a = q_a.pop_front();
          chk("a_data", 32'(data_a), 32'(e_a.data));
          chk("a_parity_err", 32'(perr_a), 32'(e_a.perr));
          chk("a_frame_err", 32'(ferr_a), 32'(e_a.ferr));
          chk("a_break_det", 32'(brk_a), 32'(e_a.brk));
        end
      end
      if (ovr_a) ovr_cnt_a++;
    end
    pv_a = valid_a;
    pt_a = os_tick;
  end

  // Monitor B.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_b && !pv_b) chk("b_valid_after_tick", 32'(pt_b), 32'd1);
      if (valid_b && ready_b) begin
        if (q_b.size() == 0) begin
          n_checks++;
          $display("FAIL b_unexpected_word: got 0x%0h expected no word", data_b);
        end else begin
          e_b = q_b.pop_front();
          chk("b_data", 32'(data_b), 32'(e_b.data));
          chk("b_parity_err", 32'(perr_b), 32'(e_b.perr));
          chk("b_frame_err", 32'(ferr_b), 32'(e_b.ferr));
          chk("b_break_det", 32'(brk_b), 32'(e_b.brk));
        end
      end
      if (ovr_b) ovr_cnt_b++;
    end
    pv_b = valid_b;
    pt_b = os_tick;
  end

  initial begin
    rst = 1'b1; rxd_a = 1'b1; rxd_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_a", 32'(valid_a), 32'd0);
    chk("rst_data_a", 32'(data_a), 32'd0);
    chk("rst_perr_a", 32'(perr_a), 32'd0);
    chk("rst_ferr_a", 32'(ferr_a), 32'd0);
    chk("rst_brk_a", 32'(brk_a), 32'd0);
    chk("rst_ovr_a", 32'(ovr_a), 32'd0);
    chk("rst_valid_b", 32'(valid_b), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_ticks(20);

    // Clean 0xA5, then bad parity, then clean 0x3C.
    push(0, 9'h0A5, 0, 0, 0); send_frame(0, 9'h0A5, 8, 1'b1, 2'b11, 1, 8);
    push(0, 9'h0A5, 1, 0, 0); send_frame(0, 9'h0A5, 8, 1'b0, 2'b11, 1, 8);
    push(0, 9'h03C, 0, 0, 0); send_frame(0, 9'h03C, 8, 1'b1, 2'b11, 1, 8);

    // Low stop bit, recovery frame, then a 2-tick glitch that must be ignored.
    push(0, 9'h05A, 0, 1, 0); send_frame(0, 9'h05A, 8, 1'b1, 2'b00, 1, 8);
    push(0, 9'h001, 0, 0, 0); send_frame(0, 9'h001, 8, 1'b0, 2'b11, 1, 8);
    drive(0, 1'b0, 2);
    drive(0, 1'b1, 24);

    // Consumer stalled: 0x11 held, 0x22 dropped with a single overrun pulse.
    ready_a = 1'b0;
    push(0, 9'h011, 0, 0, 0); send_frame(0, 9'h011, 8, 1'b1, 2'b11, 1, 8);
    send_frame(0, 9'h022, 8, 1'b1, 2'b11, 1, 8);
    @(negedge clk);
    chk("stall_data_held", 32'(data_a), 32'h11);
    chk("stall_valid_held", 32'(valid_a), 32'd1);
    chk("overrun_pulse_clks", 32'(ovr_cnt_a), 32'd1);
    @(posedge clk);
    #1 ready_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("valid_drop_after_accept", 32'(valid_a), 32'd0);

    // Break: 12 low bit periods; a low pulse before 8 high ticks must not start a frame.
    push(0, 9'h000, 0, 1, 1);
    drive(0, 1'b0, 12 * 8);
    drive(0, 1'b1, 4);
    drive(0, 1'b0, 8);
    drive(0, 1'b1, 24);
    push(0, 9'h07E, 0, 0, 0); send_frame(0, 9'h07E, 8, 1'b1, 2'b11, 1, 8);

    // 7E2 at OS16: clean 0x41, then second stop low.
    push(1, 9'h041, 0, 0, 0); send_frame(1, 9'h041, 7, 1'b0, 2'b11, 2, 16);
    push(1, 9'h041, 0, 1, 0); send_frame(1, 9'h041, 7, 1'b0, 2'b01, 2, 16);

    // Reset in the middle of the data bits abandons the frame.
    drive(1, 1'b0, 16);
    drive(1, 1'b1, 16);
    drive(1, 1'b0, 20);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    rxd_b = 1'b1;
    @(negedge clk);
    chk("midrst_valid_b", 32'(valid_b), 32'd0);
    chk("midrst_data_b", 32'(data_b), 32'd0);
    chk("midrst_flags_b", {29'd0, perr_b, ferr_b, brk_b}, 32'd0);
    chk("midrst_ovr_b", 32'(ovr_b), 32'd0);
    wait_ticks(300);

    for (int i = 0; i < 2000; i++) begin
      if (q_a.size() == 0 && q_b.size() == 0) break;
      @(posedge clk);
    end
    chk("a_pending_words", 32'(q_a.size()), 32'd0);
    chk("b_pending_words", 32'(q_b.size()), 32'd0);
    chk("b_overrun_count", 32'(ovr_cnt_b), 32'd0);
    chk("a_overrun_total", 32'(ovr_cnt_a), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
